ring_monitor: RTL and testbench

Downstream monitor for the 4-bit one-hot ring counter. It samples the ring state every clock and checks that each word is one-hot and a legal single-step rotation of the previous word. It reports the encoded phase, lock status, a revolution pulse/count, and a sticky fault flag. It shares the counter's clock and clear, and gives the sequencer side a trusted phase index.

---
 rtl/ring_pkg.sv | 31 +++
 rtl/ring_onehot_enc.sv | 36 +++
 rtl/ring_monitor.sv | 119 +++++++++++
 tb/tb_ring_monitor.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// rtl/ring_pkg.sv - shared types, defaults and rotate helper for ring-counter monitoring
//
// Contents:
//   ring_state_t : monitor FSM states (unlocked, acquiring, locked)
//   DEF_WIDTH    : default ring width
//   MAX_W        : widest ring the rotate helper supports
//   rotl1()      : rotate a ring word left by one within a given width

package ring_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQ      = 2'd1,
        ST_LOCKED   = 2'd2
    } ring_state_t;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_W     = 32;

    // Bit i moves to i+1 and bit width-1 wraps to bit 0. Bits at or above
    // width are masked so a caller can zero-extend a narrow word safely.
    function automatic logic [MAX_W-1:0] rotl1(input logic [MAX_W-1:0] word,
                                               input int               width);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] w;
        mask  = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        w     = word & mask;
        rotl1 = ((w << 1) | (w >> (width - 1))) & mask;
    endfunction

endpackage

// File: rtl/ring_onehot_enc.sv
// rtl/ring_onehot_enc.sv - combinational one-hot check and binary encoder
//
// Ports:
//   word      in  WIDTH          word to classify
//   onehot_ok out 1              exactly one bit of word is set
//   enc       out $clog2(WIDTH)  index of the set bit, 0 when word is not one-hot

module ring_onehot_enc #(
    parameter int WIDTH = ring_pkg::DEF_WIDTH
) (
    input  logic [WIDTH-1:0]         word,
    output logic                     onehot_ok,
    output logic [$clog2(WIDTH)-1:0] enc
);

    localparam int EW = $clog2(WIDTH);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [CW-1:0] bit_cnt;
    logic [EW-1:0] idx;

    always_comb begin
        bit_cnt = '0;
        idx     = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (word[i]) begin
                bit_cnt = bit_cnt + CW'(1);
                idx     = EW'(i);
            end
        end
    end

    assign onehot_ok = (bit_cnt == CW'(1));
    assign enc       = onehot_ok ? idx : '0;

endmodule

// File: rtl/ring_monitor.sv
// rtl/ring_monitor.sv - lock/wrap/fault monitor for a one-hot ring counter
//
// Ports:
//   clk       in  1              system clock, rising edge
//   clear     in  1              synchronous active-high reset
//   ring_in   in  WIDTH          ring counter state, sampled every edge
//   enc       out $clog2(WIDTH)  index of set bit in last sample (0 if not one-hot)
//   onehot_ok out 1              last sample was one-hot
//   locked    out 1              monitor is in the locked state
//   wrap      out 1              one-cycle pulse on a legal advance from top bit to bit 0
//   rev_count out REV_W          number of wrap pulses, modulo 2^REV_W
//   err       out 1              sticky: sequence broke while locked

module ring_monitor
    import ring_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int LOCK_CNT = 4,
    parameter int REV_W    = 8
) (
    input  logic                     clk,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         ring_in,
    output logic [$clog2(WIDTH)-1:0] enc,
    output logic                     onehot_ok,
    output logic                     locked,
    output logic                     wrap,
    output logic [REV_W-1:0]         rev_count,
    output logic                     err
);

    localparam int                AW    = $clog2(LOCK_CNT + 1);
    localparam logic [AW-1:0]     LOCK_V = AW'(LOCK_CNT);

    ring_state_t                state;
    logic [AW-1:0]              adv_cnt;
    logic [AW-1:0]              adv_nxt;
    logic [WIDTH-1:0]           prev_q;
    logic [WIDTH-1:0]           prev_rot;
    logic                       word_ok;
    logic [$clog2(WIDTH)-1:0]   word_enc;
    logic                       is_adv;
    logic                       is_wrap;

    ring_onehot_enc #(.WIDTH(WIDTH)) u_enc (
        .word      (ring_in),
        .onehot_ok (word_ok),
        .enc       (word_enc)
    );

    assign prev_rot = WIDTH'(rotl1(MAX_W'(prev_q), WIDTH));
    // A legal advance must itself be a legal word; this also rejects a
    // zero previous sample, whose rotation is zero.
    assign is_adv   = word_ok && (ring_in == prev_rot);
    assign is_wrap  = is_adv && ring_in[0];
    assign adv_nxt  = adv_cnt + AW'(1);

    always_ff @(posedge clk) begin
        if (clear) begin
            state     <= ST_UNLOCKED;
            adv_cnt   <= '0;
            prev_q    <= '0;
            enc       <= '0;
            onehot_ok <= 1'b0;
            locked    <= 1'b0;
            wrap      <= 1'b0;
            rev_count <= '0;
            err       <= 1'b0;
        end else begin
            prev_q    <= ring_in;
            enc       <= word_enc;
            onehot_ok <= word_ok;
            wrap      <= 1'b0;

            case (state)
                ST_UNLOCKED: begin
                    if (word_ok) begin
                        state   <= ST_ACQ;
                        adv_cnt <= '0;
                    end
                end
                ST_ACQ: begin
                    if (is_adv) begin
                        adv_cnt <= adv_nxt;
                        if (adv_nxt == LOCK_V) begin
                            state  <= ST_LOCKED;
                            locked <= 1'b1;
                        end
                    end else if (word_ok) begin
                        adv_cnt <= '0;
                    end else begin
                        state   <= ST_UNLOCKED;
                        adv_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (!is_adv) begin
                        state   <= word_ok ? ST_ACQ : ST_UNLOCKED;
                        adv_cnt <= '0;
                        locked  <= 1'b0;
                        err     <= 1'b1;
                    end
                end
                default: begin
                    state   <= ST_UNLOCKED;
                    adv_cnt <= '0;
                    locked  <= 1'b0;
                end
            endcase

            // Revolutions only count once the monitor has seen a legal word.
            if (is_wrap && (state != ST_UNLOCKED)) begin
                wrap      <= 1'b1;
                rev_count <= rev_count + REV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_ring_monitor.sv
// tb/tb_ring_monitor.sv - directed self-checking bench for ring_monitor

module tb_ring_monitor;

    logic       clk;
    logic       clear;
    logic [3:0] ring_in;

    logic [1:0] enc;
    logic       onehot_ok;
    logic       locked;
    logic       wrap;
    logic [7:0] rev_count;
    logic       err;

    logic [1:0] enc2;
    logic       onehot_ok2;
    logic       locked2;
    logic       wrap2;
    logic [1:0] rev_count2;
    logic       err2;

    int vectors;
    int miscompares;

    ring_monitor dut (
        .clk       (clk),
        .clear     (clear),
        .ring_in   (ring_in),
        .enc       (enc),
        .onehot_ok (onehot_ok),
        .locked    (locked),
        .wrap      (wrap),
        .rev_count (rev_count),
        .err       (err)
    );

    ring_monitor #(.WIDTH(4), .LOCK_CNT(4), .REV_W(2)) dut2 (
        .clk       (clk),
        .clear     (clear),
        .ring_in   (ring_in),
        .enc       (enc2),
        .onehot_ok (onehot_ok2),
        .locked    (locked2),
        .wrap      (wrap2),
        .rev_count (rev_count2),
        .err       (err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(input string tag, input logic [1:0] e_enc, input logic e_ok,
                           input logic e_lk, input logic e_wrap, input logic [7:0] e_rev,
                           input logic e_err);
        chk({tag, ".enc"},       32'(enc),       32'(e_enc));
        chk({tag, ".onehot_ok"}, 32'(onehot_ok), 32'(e_ok));
        chk({tag, ".locked"},    32'(locked),    32'(e_lk));
        chk({tag, ".wrap"},      32'(wrap),      32'(e_wrap));
        chk({tag, ".rev_count"}, 32'(rev_count), 32'(e_rev));
        chk({tag, ".err"},       32'(err),       32'(e_err));
    endtask

    // Inputs change on the falling edge; outputs are read 1 ns after the rising edge.
    task automatic step(input logic [3:0] w, input logic clr);
        @(negedge clk);
        ring_in = w;
        clear   = clr;
        @(posedge clk);
        #1;
    endtask

    // Clear, then 0001,0010,0100,1000,0001: locked with one wrap, prev sample 0001.
    task automatic relock();
        step(4'b0000, 1'b1);
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        clear       = 1'b1;
        ring_in     = 4'b0000;

        // Reset
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        chk_all("reset", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("reset.rev2", 32'(rev_count2), 32'd0);

        // Lock and first wrap
        step(4'b0001, 1'b0); chk_all("acq_s1", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0010, 1'b0); chk_all("acq_s2", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0100, 1'b0); chk_all("acq_s3", 2'd2, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b1000, 1'b0); chk_all("acq_s4", 2'd3, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0001, 1'b0); chk_all("lock_s5", 2'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
        step(4'b0010, 1'b0); chk_all("post_lock", 2'd1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0); chk_all("wrap2", 2'd0, 1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0); chk_all("wrap3", 2'd0, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0);

        // Glitch while locked
        step(4'b0110, 1'b0); chk_all("glitch", 2'd0, 1'b0, 1'b0, 1'b0, 8'd3, 1'b1);
        step(4'b0010, 1'b0); chk("reacq1.locked", 32'(locked), 32'd0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0); chk_all("reacq4", 2'd0, 1'b1, 1'b0, 1'b1, 8'd4, 1'b1);
        step(4'b0010, 1'b0); chk_all("reacq5", 2'd1, 1'b1, 1'b1, 1'b0, 8'd4, 1'b1);

        // Hold while locked
        relock();
        chk_all("hold_relock", 2'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);
        step(4'b0010, 1'b0); chk_all("hold_pre", 2'd1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);
        step(4'b0010, 1'b0); chk_all("hold", 2'd1, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
        step(4'b0100, 1'b0); chk("hold_a1.locked", 32'(locked), 32'd0);
        step(4'b1000, 1'b0); chk("hold_a2.locked", 32'(locked), 32'd0);
        step(4'b0001, 1'b0); chk_all("hold_a3", 2'd0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1);
        step(4'b0010, 1'b0); chk_all("hold_a4", 2'd1, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1);

        // Skip while locked
        relock();
        step(4'b0100, 1'b0); chk_all("skip", 2'd2, 1'b1, 1'b0, 1'b0, 8'd1, 1'b1);
        step(4'b1000, 1'b0); chk("skip_a1.locked", 32'(locked), 32'd0);
        step(4'b0001, 1'b0); chk_all("skip_a2", 2'd0, 1'b1, 1'b0, 1'b1, 8'd2, 1'b1);
        step(4'b0010, 1'b0); chk("skip_a3.locked", 32'(locked), 32'd0);
        step(4'b0100, 1'b0); chk_all("skip_a4", 2'd2, 1'b1, 1'b1, 1'b0, 8'd2, 1'b1);

        // Rollover on the 2-bit counter instance
        relock();
        chk("roll_lock.rev2", 32'(rev_count2), 32'd1);
        chk("roll_lock.wrap2", 32'(wrap2), 32'd1);
        for (int r = 0; r < 4; r++) begin
            step(4'b0010, 1'b0);
            chk("roll.wrap2_low", 32'(wrap2), 32'd0);
            step(4'b0100, 1'b0);
            step(4'b1000, 1'b0);
            step(4'b0001, 1'b0);
            chk("roll.wrap2_high", 32'(wrap2), 32'd1);
            chk("roll.rev2", 32'(rev_count2), 32'((2 + r) % 4));
            chk("roll.rev", 32'(rev_count), 32'(2 + r));
        end

        // Clear on the cycle that would wrap
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        chk("pre_clear.locked", 32'(locked), 32'd1);
        step(4'b0001, 1'b1); chk_all("clear_wrap", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        chk("clear_wrap.wrap2", 32'(wrap2), 32'd0);
        step(4'b0001, 1'b0); chk_all("rl_s1", 2'd0, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0); chk("rl_s4.locked", 32'(locked), 32'd0);
        step(4'b0001, 1'b0); chk_all("rl_s5", 2'd0, 1'b1, 1'b1, 1'b1, 8'd1, 1'b0);

        // Zero words and reverse rotation
        step(4'b0000, 1'b1);
        step(4'b0000, 1'b0); chk_all("zero1", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0000, 1'b0); chk_all("zero2", 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0010, 1'b0); chk_all("reverse", 2'd1, 1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0); chk_all("rev_a3", 2'd0, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
        step(4'b0010, 1'b0); chk_all("rev_a4", 2'd1, 1'b1, 1'b1, 1'b0, 8'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
